// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, control-bundle bit positions and
// architecturally special register numbers. Imported by the ID/EX stage and
// its bypass multiplexers.
package cpu_pkg;

    localparam int DW     = 32;   // data / PC width
    localparam int RW     = 5;    // register-number width
    localparam int CTRL_W = 12;   // decoded control-bundle width

    // Control-bundle bit indices
    localparam int CTRL_MEMREAD  = 0;   // instruction is a load
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_JAL      = 3;
    localparam int CTRL_BRANCH   = 4;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_ALUOP_LO = 6;   // ALU op occupies bits 9:6
    localparam int CTRL_ALUOP_HI = 9;
    localparam int CTRL_MEMTOREG = 10;
    localparam int CTRL_JUMP     = 11;

    // Special register numbers
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

endpackage

// File: rtl/id_bypass_mux.sv
// WB-to-ID bypass for one source operand.
// The register file writes on the clock edge but reads combinationally, so an
// operand read in the same cycle WB writes it would return the stale value.
// This mux substitutes the WB data when WB targets the operand's register.
// Ports:
//   src        source register number of the ID operand
//   reg_val    register-file read value for src
//   wb_we      WB write qualifier (regwrite or JAL link write)
//   wb_regnum  WB destination register
//   wb_data    WB write data
//   op         corrected operand
module id_bypass_mux
    import cpu_pkg::*;
#(
    parameter int DW         = 32,
    parameter int RW         = 5,
    parameter bit ZERO_GUARD = 1'b1
) (
    input  logic [RW-1:0] src,
    input  logic [DW-1:0] reg_val,
    input  logic          wb_we,
    input  logic [RW-1:0] wb_regnum,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] op
);

    logic src_is_zero;
    logic hit;

    assign src_is_zero = (src == RW'(REG_ZERO));
    // A write to r0 is architecturally discarded, so it must never be forwarded.
    assign hit = wb_we && (wb_regnum == src) && !(ZERO_GUARD && src_is_zero);
    assign op  = hit ? wb_data : reg_val;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline latch placed directly after the register file.
//  - Captures operands, immediate, PC, register numbers and control for EX.
//  - Forwards same-cycle WB writes into both read operands.
//  - Detects a load in EX feeding the ID instruction and inserts one bubble,
//    counting inserted bubbles in a saturating counter.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    hold all EX state
//   flush                    kill the ID instruction (EX becomes a bubble)
//   id_*                     decoded ID instruction fields
//   reg_a, reg_b             register-file read data for id_rs / id_rt
//   wb_regwrite, wb_jal      WB write qualifiers
//   wb_regnum, wb_data       WB destination and data
//   ex_*                     latched EX instruction
//   load_use_stall           combinational: ID/IF must hold this cycle
//   bubble_cnt               number of load-use bubbles inserted (saturating)
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DW         = cpu_pkg::DW,
    parameter int RW         = cpu_pkg::RW,
    parameter int CTRL_W     = cpu_pkg::CTRL_W,
    parameter bit ZERO_GUARD = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DW-1:0]     id_pc,
    input  logic [RW-1:0]     id_rs,
    input  logic [RW-1:0]     id_rt,
    input  logic              id_uses_rt,
    input  logic [RW-1:0]     id_rd,
    input  logic [DW-1:0]     id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DW-1:0]     reg_a,
    input  logic [DW-1:0]     reg_b,
    input  logic              wb_regwrite,
    input  logic              wb_jal,
    input  logic [RW-1:0]     wb_regnum,
    input  logic [DW-1:0]     wb_data,
    output logic              ex_valid,
    output logic [DW-1:0]     ex_pc,
    output logic [DW-1:0]     ex_a,
    output logic [DW-1:0]     ex_b,
    output logic [DW-1:0]     ex_imm,
    output logic [RW-1:0]     ex_rs,
    output logic [RW-1:0]     ex_rt,
    output logic [RW-1:0]     ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              load_use_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // ---------------------------------------------------------------- bypass
    logic          wb_we;
    logic [RW-1:0] byp_src [2];
    logic [DW-1:0] byp_reg [2];
    logic [DW-1:0] byp_op  [2];

    assign wb_we      = wb_regwrite | wb_jal;
    assign byp_src[0] = id_rs;
    assign byp_src[1] = id_rt;
    assign byp_reg[0] = reg_a;
    assign byp_reg[1] = reg_b;

    for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
        id_bypass_mux #(
            .DW         (DW),
            .RW         (RW),
            .ZERO_GUARD (ZERO_GUARD)
        ) u_bypass (
            .src       (byp_src[gi]),
            .reg_val   (byp_reg[gi]),
            .wb_we     (wb_we),
            .wb_regnum (wb_regnum),
            .wb_data   (wb_data),
            .op        (byp_op[gi])
        );
    end

    // ------------------------------------------------------ pipeline registers
    logic              ex_valid_reg;
    logic [DW-1:0]     ex_pc_reg;
    logic [DW-1:0]     ex_a_reg;
    logic [DW-1:0]     ex_b_reg;
    logic [DW-1:0]     ex_imm_reg;
    logic [RW-1:0]     ex_rs_reg;
    logic [RW-1:0]     ex_rt_reg;
    logic [RW-1:0]     ex_rd_reg;
    logic [CTRL_W-1:0] ex_ctrl_reg;
    logic [CNT_W-1:0]  bubble_cnt_reg;

    // ------------------------------------------------------- load-use hazard
    logic ex_rd_live;
    logic rd_matches;

    // A load into r0 produces nothing a later instruction can depend on.
    assign ex_rd_live = !(ZERO_GUARD && (ex_rd_reg == RW'(REG_ZERO)));
    // rt only creates a dependency when it is really read (not a destination).
    assign rd_matches = (ex_rd_reg == id_rs) || (id_uses_rt && (ex_rd_reg == id_rt));
    assign load_use_stall = id_valid && ex_valid_reg && ex_ctrl_reg[CTRL_MEMREAD]
                            && ex_rd_live && rd_matches;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_valid_reg <= 1'b0;
            ex_pc_reg    <= '0;
            ex_a_reg     <= '0;
            ex_b_reg     <= '0;
            ex_imm_reg   <= '0;
            ex_rs_reg    <= '0;
            ex_rt_reg    <= '0;
            ex_rd_reg    <= '0;
            ex_ctrl_reg  <= '0;
        end else if (stall) begin
            // hold: EX keeps its instruction, hazard is re-evaluated next cycle
        end else if (load_use_stall) begin
            ex_valid_reg <= 1'b0;
            ex_pc_reg    <= '0;
            ex_a_reg     <= '0;
            ex_b_reg     <= '0;
            ex_imm_reg   <= '0;
            ex_rs_reg    <= '0;
            ex_rt_reg    <= '0;
            ex_rd_reg    <= '0;
            ex_ctrl_reg  <= '0;
        end else begin
            ex_valid_reg <= id_valid;
            ex_pc_reg    <= id_pc;
            ex_a_reg     <= byp_op[0];
            ex_b_reg     <= byp_op[1];
            ex_imm_reg   <= id_imm;
            ex_rs_reg    <= id_rs;
            ex_rt_reg    <= id_rt;
            ex_rd_reg    <= id_rd;
            ex_ctrl_reg  <= id_valid ? id_ctrl : '0;
        end
    end

    // Only bubbles actually inserted are counted: a flush or a stall in the
    // same cycle suppresses the increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_reg <= '0;
        end else if (!flush && !stall && load_use_stall && (bubble_cnt_reg != '1)) begin
            bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
        end
    end

    assign ex_valid   = ex_valid_reg;
    assign ex_pc      = ex_pc_reg;
    assign ex_a       = ex_a_reg;
    assign ex_b       = ex_b_reg;
    assign ex_imm     = ex_imm_reg;
    assign ex_rs      = ex_rs_reg;
    assign ex_rt      = ex_rt_reg;
    assign ex_rd      = ex_rd_reg;
    assign ex_ctrl    = ex_ctrl_reg;
    assign bubble_cnt = bubble_cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam logic [11:0] ALU = 12'h002;
    localparam logic [11:0] LD  = 12'h003;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        id_valid, id_uses_rt;
    logic [31:0] id_pc, id_imm, reg_a, reg_b, wb_data;
    logic [4:0]  id_rs, id_rt, id_rd, wb_regnum;
    logic [11:0] id_ctrl;
    logic        wb_regwrite, wb_jal;
    logic        ex_valid, load_use_stall;
    logic [31:0] ex_pc, ex_a, ex_b, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [11:0] ex_ctrl;
    logic [1:0]  bubble_cnt;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic        v;
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs, rt, rd;
        logic [11:0] ctrl;
        logic [1:0]  cnt;
    } ex_t;

    ex_t   exp_q[$];
    string name_q[$];

    id_ex_stage #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .reg_a(reg_a), .reg_b(reg_b),
        .wb_regwrite(wb_regwrite), .wb_jal(wb_jal), .wb_regnum(wb_regnum), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic ex_t mk(input logic v, input logic [31:0] pc, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] imm,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic [11:0] ctrl, input logic [1:0] cnt);
        ex_t e;
        e.v = v; e.pc = pc; e.a = a; e.b = b; e.imm = imm;
        e.rs = rs; e.rt = rt; e.rd = rd; e.ctrl = ctrl; e.cnt = cnt;
        return e;
    endfunction

    function automatic ex_t bubble(input logic [1:0] cnt);
        return mk(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 12'h0, cnt);
    endfunction

    // Monitor: pops one expected EX state per clock edge that the driver announced.
    always @(posedge clk) begin
        ex_t   e;
        string n;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (ex_valid !== e.v || ex_pc !== e.pc || ex_a !== e.a || ex_b !== e.b ||
                ex_imm !== e.imm || ex_rs !== e.rs || ex_rt !== e.rt || ex_rd !== e.rd ||
                ex_ctrl !== e.ctrl || bubble_cnt !== e.cnt) begin
                fails++;
                $display("FAIL %s: got v=%b pc=%h a=%h b=%h imm=%h rs=%0d rt=%0d rd=%0d ctrl=%h cnt=%0d ; want v=%b pc=%h a=%h b=%h imm=%h rs=%0d rt=%0d rd=%0d ctrl=%h cnt=%0d",
                         n, ex_valid, ex_pc, ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_rd, ex_ctrl, bubble_cnt,
                         e.v, e.pc, e.a, e.b, e.imm, e.rs, e.rt, e.rd, e.ctrl, e.cnt);
            end else begin
                $display("ok   %s: v=%b pc=%h a=%h b=%h rd=%0d ctrl=%h cnt=%0d",
                         n, ex_valid, ex_pc, ex_a, ex_b, ex_rd, ex_ctrl, bubble_cnt);
            end
        end
    end

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                          input logic [4:0] rt, input logic ut, input logic [4:0] rd,
                          input logic [31:0] imm, input logic [11:0] ctrl);
        id_valid = v; id_pc = pc; id_rs = rs; id_rt = rt; id_uses_rt = ut;
        id_rd = rd; id_imm = imm; id_ctrl = ctrl;
    endtask

    task automatic set_rf(input logic [31:0] a, input logic [31:0] b);
        reg_a = a; reg_b = b;
    endtask

    task automatic set_wb(input logic we, input logic jal, input logic [4:0] num,
                          input logic [31:0] data);
        wb_regwrite = we; wb_jal = jal; wb_regnum = num; wb_data = data;
    endtask

    // Called just after a negedge with inputs applied: checks the combinational
    // hazard output (lus < 0 skips it), announces the EX state expected after
    // the next rising edge, then advances to the following negedge.
    task automatic tick(input string n, input int lus, input ex_t e);
        #1;
        if (lus >= 0) begin
            checks++;
            if (load_use_stall !== lus[0]) begin
                fails++;
                $display("FAIL %s load_use_stall: got %b want %0d", n, load_use_stall, lus);
            end
        end
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] cnt_before [5];
        logic [1:0] cnt_after  [5];
        int         waited;
        ex_t        ent;
        cnt_before = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        cnt_after  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        set_id(1'b0, 0, 0, 0, 1'b0, 0, 0, 12'h0);
        set_rf(0, 0);
        set_wb(1'b0, 1'b0, 0, 0);
        @(negedge clk);

        // 1. reset with random inputs
        for (int i = 0; i < 2; i++) begin
            stall = 1'($urandom); flush = 1'($urandom);
            set_id(1'($urandom), $urandom, 5'($urandom), 5'($urandom), 1'($urandom),
                   5'($urandom), $urandom, 12'($urandom));
            set_rf($urandom, $urandom);
            set_wb(1'($urandom), 1'($urandom), 5'($urandom), $urandom);
            tick("reset", (i == 0) ? -1 : 0, bubble(2'd0));
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;

        // 2. WB bypass into rs; r0 is never bypassed
        set_id(1, 32'h100, 5, 6, 1, 7, 32'h4, ALU); set_rf(32'h11, 32'h22); set_wb(1, 0, 5, 32'hABCD);
        tick("bypass_rs", 0, mk(1, 32'h100, 32'hABCD, 32'h22, 32'h4, 5, 6, 7, ALU, 0));
        set_id(1, 32'h104, 0, 0, 1, 9, 32'h8, ALU); set_rf(32'h33, 32'h44); set_wb(1, 0, 0, 32'hDEAD);
        tick("bypass_r0", 0, mk(1, 32'h104, 32'h33, 32'h44, 32'h8, 0, 0, 9, ALU, 0));

        // 3. JAL link write bypassed into rt
        set_id(1, 32'h108, 1, 31, 1, 2, 32'hC, ALU); set_rf(32'h55, 32'h66); set_wb(0, 1, 31, 32'h40);
        tick("jal_bypass", 0, mk(1, 32'h108, 32'h55, 32'h40, 32'hC, 1, 31, 2, ALU, 0));

        // 4. load-use via rs; WB writes the load's rd in the detection cycle
        set_id(1, 32'h10C, 2, 8, 0, 8, 32'h10, LD); set_rf(32'h77, 32'h88); set_wb(0, 0, 2, 32'hBAD);
        tick("load_enter", 0, mk(1, 32'h10C, 32'h77, 32'h88, 32'h10, 2, 8, 8, LD, 0));
        set_id(1, 32'h110, 8, 3, 1, 4, 32'h14, ALU); set_rf(32'h99, 32'hAA); set_wb(1, 0, 8, 32'h1111);
        tick("load_use_rs", 1, bubble(2'd1));
        set_wb(1, 0, 8, 32'h5678);
        tick("lu_retry", 0, mk(1, 32'h110, 32'h5678, 32'hAA, 32'h14, 8, 3, 4, ALU, 1));

        // load-use via rt
        set_id(1, 32'h114, 1, 0, 0, 10, 0, LD); set_rf(32'h1, 32'h2); set_wb(0, 0, 0, 0);
        tick("load2_enter", 0, mk(1, 32'h114, 32'h1, 32'h2, 0, 1, 0, 10, LD, 1));
        set_id(1, 32'h118, 0, 10, 1, 11, 0, ALU); set_rf(32'h3, 32'h4);
        tick("load_use_rt", 1, bubble(2'd2));
        tick("rt_retry", 0, mk(1, 32'h118, 32'h3, 32'h4, 0, 0, 10, 11, ALU, 2));

        // 5. flush beats load-use, counter unchanged
        set_id(1, 32'h11C, 0, 0, 0, 12, 0, LD); set_rf(32'h5, 32'h6);
        tick("load3_enter", 0, mk(1, 32'h11C, 32'h5, 32'h6, 0, 0, 0, 12, LD, 2));
        set_id(1, 32'h120, 12, 0, 0, 13, 0, ALU); set_rf(32'h7, 32'h8); flush = 1'b1;
        tick("flush_vs_lu", 1, bubble(2'd2));
        flush = 1'b0;

        // stall holds EX for 3 cycles while ID changes
        set_id(1, 32'h124, 1, 2, 1, 14, 0, ALU); set_rf(32'hA, 32'hB);
        ent = mk(1, 32'h124, 32'hA, 32'hB, 0, 1, 2, 14, ALU, 2);
        tick("pre_stall", 0, ent);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 32'h200 + 32'(i), 5'(3 + i), 5'(4 + i), 1, 5'(20 + i), 32'hFF, LD);
            set_rf(32'hF0 + 32'(i), 32'hE0 + 32'(i)); set_wb(1, 0, 5'(3 + i), 32'hCAFE);
            tick("stall_hold", 0, ent);
        end
        stall = 1'b0; set_wb(0, 0, 0, 0);

        // stall with load-use: EX holds, hazard persists and bubbles afterwards
        set_id(1, 32'h128, 0, 0, 0, 15, 0, LD); set_rf(32'hC, 32'hD);
        ent = mk(1, 32'h128, 32'hC, 32'hD, 0, 0, 0, 15, LD, 2);
        tick("load4_enter", 0, ent);
        set_id(1, 32'h12C, 15, 0, 0, 16, 0, ALU); set_rf(32'hE, 32'hF); stall = 1'b1;
        tick("stall_vs_lu", 1, ent);
        stall = 1'b0;
        tick("lu_after_stall", 1, bubble(2'd3));

        // reset in the middle of a stalled load-use discards everything
        set_id(1, 32'h130, 0, 0, 0, 17, 0, LD); set_rf(32'h1, 32'h1);
        tick("load5_enter", 0, mk(1, 32'h130, 32'h1, 32'h1, 0, 0, 0, 17, LD, 3));
        set_id(1, 32'h134, 17, 0, 0, 18, 0, ALU); set_rf(32'h2, 32'h3); stall = 1'b1; rst = 1'b1;
        tick("reset_mid_stall", 1, bubble(2'd0));
        stall = 1'b0; rst = 1'b0;
        tick("after_reset", 0, mk(1, 32'h134, 32'h2, 32'h3, 0, 17, 0, 18, ALU, 0));

        // 6. saturation of the 2-bit bubble counter over 5 bubbles
        for (int i = 0; i < 5; i++) begin
            set_id(1, 32'h300 + 32'(8 * i), 0, 0, 0, 20, 0, LD); set_rf(32'(i), 32'(i + 1));
            tick("sat_load", 0, mk(1, 32'h300 + 32'(8 * i), 32'(i), 32'(i + 1), 0, 0, 0, 20, LD,
                                   cnt_before[i]));
            set_id(1, 32'h304 + 32'(8 * i), 20, 0, 0, 21, 0, ALU);
            tick("sat_bubble", 1, bubble(cnt_after[i]));
        end

        // id_valid=0 never hazards and enters EX with ctrl cleared
        set_id(1, 32'h400, 0, 0, 0, 22, 0, LD); set_rf(32'h9, 32'h9);
        tick("load6_enter", 0, mk(1, 32'h400, 32'h9, 32'h9, 0, 0, 0, 22, LD, 3));
        set_id(0, 32'h404, 22, 22, 1, 23, 32'h5, ALU);
        tick("invalid_id", 0, mk(0, 32'h404, 32'h9, 32'h9, 32'h5, 22, 22, 23, 12'h0, 3));

        // load into r0 never causes a hazard
        set_id(1, 32'h408, 1, 0, 0, 0, 0, LD); set_rf(32'h21, 32'h22);
        tick("load_r0_enter", 0, mk(1, 32'h408, 32'h21, 32'h22, 0, 1, 0, 0, LD, 3));
        set_id(1, 32'h40C, 0, 0, 1, 24, 0, ALU); set_rf(32'h31, 32'h32);
        tick("r0_no_hazard", 0, mk(1, 32'h40C, 32'h31, 32'h32, 0, 0, 0, 24, ALU, 3));

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d expected entries never checked, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
